// File: rtl/iob_cache_write_arbiter.sv
// Round-robin arbiter that funnels N_REQ write requesters into one write channel
// through a single-entry buffer (grant in IDLE, present in SEND until accepted).
module iob_cache_write_arbiter #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32,
   parameter int STRB_W = DATA_W / 8,
   parameter int ID_W   = $clog2(N_REQ)
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [N_REQ-1:0]          req_valid_i,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
   input  logic [N_REQ*STRB_W-1:0]   req_wstrb_i,
   output logic [N_REQ-1:0]          req_ready_o,
   output logic                      m_valid_o,
   output logic [ADDR_W-1:0]         m_addr_o,
   output logic [DATA_W-1:0]         m_wdata_o,
   output logic [STRB_W-1:0]         m_wstrb_o,
   input  logic                      m_ready_i,
   output logic [ID_W-1:0]           grant_id_o,
   output logic                      busy_o
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t              state_reg, state_next;
   logic [ID_W-1:0]     rr_ptr_reg, rr_ptr_next;
   logic [ID_W-1:0]     grant_id_reg, grant_id_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [DATA_W-1:0]   wdata_reg, wdata_next;
   logic [STRB_W-1:0]   wstrb_reg, wstrb_next;

   logic [ADDR_W-1:0]   req_addr  [N_REQ];
   logic [DATA_W-1:0]   req_wdata [N_REQ];
   logic [STRB_W-1:0]   req_wstrb [N_REQ];

   logic                found;
   logic [ID_W-1:0]     win;
   logic [ID_W:0]       cand;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign req_addr[gi]  = req_addr_i[gi*ADDR_W +: ADDR_W];
         assign req_wdata[gi] = req_wdata_i[gi*DATA_W +: DATA_W];
         assign req_wstrb[gi] = req_wstrb_i[gi*STRB_W +: STRB_W];
      end
   endgenerate

   // Scan rr_ptr, rr_ptr+1, ... with wrap; the extra bit of cand absorbs the overflow.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(i);
         if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
         if (!found && req_valid_i[cand[ID_W-1:0]]) begin
            found = 1'b1;
            win   = cand[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg    <= IDLE;
         rr_ptr_reg   <= '0;
         grant_id_reg <= '0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         wstrb_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         rr_ptr_reg   <= rr_ptr_next;
         grant_id_reg <= grant_id_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         wstrb_reg    <= wstrb_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      rr_ptr_next   = rr_ptr_reg;
      grant_id_next = grant_id_reg;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      wstrb_next    = wstrb_reg;
      case (state_reg)
         IDLE: begin
            if (found) begin
               state_next    = SEND;
               grant_id_next = win;
               addr_next     = req_addr[win];
               wdata_next    = req_wdata[win];
               wstrb_next    = req_wstrb[win];
               rr_ptr_next   = (win == ID_W'(N_REQ-1)) ? '0 : win + ID_W'(1);
            end
         end
         SEND: begin
            if (m_ready_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = '0;
      m_valid_o   = 1'b0;
      busy_o      = 1'b0;
      if (state_reg == IDLE) begin
         if (found) req_ready_o[win] = 1'b1;
      end else begin
         m_valid_o = 1'b1;
         busy_o    = 1'b1;
      end
   end

   assign m_addr_o   = addr_reg;
   assign m_wdata_o  = wdata_reg;
   assign m_wstrb_o  = wstrb_reg;
   assign grant_id_o = grant_id_reg;

endmodule
